// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared constants, types and helpers for the TMDS channel encoder
package tmds_pkg;

    // Control-period tokens, indexed by {C1,C0}
    localparam logic [9:0] TMDS_CTL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTL_11 = 10'h2AB;

    // S1 bundle: raw pixel plus its ones count
    typedef struct packed {
        logic [7:0] d;
        logic [3:0] n1d;
        logic       de;
        logic [1:0] c;
    } tmds_s1_t;

    // S2 bundle: transition-minimised word plus its ones count
    typedef struct packed {
        logic [8:0] q_m;
        logic [3:0] n1q;
        logic       de;
        logic [1:0] c;
    } tmds_s2_t;

    // Which DC-balance branch the S3 stage takes for a data word
    typedef enum logic [1:0] {
        BAL_A = 2'd0,
        BAL_B = 2'd1,
        BAL_C = 2'd2
    } tmds_bal_e;

    // Number of ones in an 8-bit word (0..8)
    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Control token selected by {C1,C0}
    function automatic logic [9:0] ctl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TMDS_CTL_00;
            2'b01:   t = TMDS_CTL_01;
            2'b10:   t = TMDS_CTL_10;
            default: t = TMDS_CTL_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_encoder_qm_stage.sv
// rtl/tmds_encoder_qm_stage.sv - combinational XOR/XNOR transition minimiser, D -> q_m[8:0]
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] d_i,
    input  logic [3:0] n1d_i,
    output logic [8:0] q_m_o
);

    logic use_xnor;

    // Chain each bit against the previous output bit; q_m[8]=1 marks the XOR chain
    function automatic logic [8:0] minimise(input logic [7:0] d, input logic xn);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~xn;
        return q;
    endfunction

    // XNOR chain when the word is ones-heavy (ties broken by D[0]=0), else XOR chain
    always_comb begin
        use_xnor = (n1d_i > 4'd4) || ((n1d_i == 4'd4) && !d_i[0]);
        q_m_o    = minimise(d_i, use_xnor);
    end

endmodule

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - three-stage TMDS 8b/10b channel encoder with running-disparity balance
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                    PCLK,
    input  logic                    RESET,
    input  logic                    DE,
    input  logic                    C0,
    input  logic                    C1,
    input  logic [7:0]              D,
    output logic [9:0]              Q,
    output logic signed [CNT_W-1:0] DISP
);

    localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
    localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);

    tmds_s1_t                s1_d, s1_q;
    tmds_s2_t                s2_d, s2_q;
    logic [8:0]              q_m;
    logic [9:0]              q_d, q_q;
    logic signed [CNT_W-1:0] cnt_d, cnt_q;

    logic signed [CNT_W-1:0] n1q_s, n0q_s, diff_s;
    logic                    cnt_pos, cnt_neg, cnt_zero;
    logic                    ones_heavy, zeros_heavy, balanced;
    tmds_bal_e               bal_case;

    // S1 input capture; pixel is zeroed outside the data period so junk on D never enters the pipe
    always_comb begin
        s1_d.d   = DE ? D : 8'd0;
        s1_d.n1d = popcnt8(DE ? D : 8'd0);
        s1_d.de  = DE;
        s1_d.c   = {C1, C0};
    end

    tmds_qm_stage u_qm (
        .d_i   (s1_q.d),
        .n1d_i (s1_q.n1d),
        .q_m_o (q_m)
    );

    // S2 bundle: minimised word plus its ones count, control travels alongside
    always_comb begin
        s2_d.q_m = q_m;
        s2_d.n1q = popcnt8(q_m[7:0]);
        s2_d.de  = s1_q.de;
        s2_d.c   = s1_q.c;
    end

    // Classify the S2 word against the running disparity
    always_comb begin
        n1q_s       = signed'({{(CNT_W-4){1'b0}}, s2_q.n1q});
        n0q_s       = EIGHT - n1q_s;
        diff_s      = n1q_s - n0q_s;
        cnt_zero    = (cnt_q == '0);
        cnt_neg     = cnt_q[CNT_W-1];
        cnt_pos     = !cnt_neg && !cnt_zero;
        balanced    = (s2_q.n1q == 4'd4);
        ones_heavy  = (s2_q.n1q > 4'd4);
        zeros_heavy = (s2_q.n1q < 4'd4);
        bal_case    = BAL_C;
        if (cnt_zero || balanced) begin
            bal_case = BAL_A;
        end else if ((cnt_pos && ones_heavy) || (cnt_neg && zeros_heavy)) begin
            bal_case = BAL_B;
        end
    end

    // S3 next symbol and disparity; a control word emits its token and clears the count
    always_comb begin
        q_d   = ctl_token(s2_q.c);
        cnt_d = '0;
        if (s2_q.de) begin
            case (bal_case)
                BAL_A: begin
                    q_d   = {~s2_q.q_m[8], s2_q.q_m[8],
                             s2_q.q_m[8] ? s2_q.q_m[7:0] : ~s2_q.q_m[7:0]};
                    cnt_d = s2_q.q_m[8] ? (cnt_q + diff_s) : (cnt_q - diff_s);
                end
                BAL_B: begin
                    q_d   = {1'b1, s2_q.q_m[8], ~s2_q.q_m[7:0]};
                    cnt_d = cnt_q - diff_s + (s2_q.q_m[8] ? TWO : '0);
                end
                default: begin
                    q_d   = {1'b0, s2_q.q_m[8], s2_q.q_m[7:0]};
                    cnt_d = cnt_q + diff_s - (s2_q.q_m[8] ? '0 : TWO);
                end
            endcase
        end
    end

    // Pipeline registers; reset leaves a control-00 word in flight and clears the output
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            s1_q  <= '0;
            s2_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign Q    = q_q;
    assign DISP = cnt_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - self-checking bench for tmds_encoder against a DVI 1.0 behavioural model
module tb_tmds_encoder;

    localparam int CNT_W = 5;

    typedef struct packed {
        bit       de;
        bit [1:0] c;
        bit [7:0] d;
    } word_t;

    logic                    pclk = 1'b0;
    logic                    rst  = 1'b1;
    logic                    de   = 1'b0;
    logic                    c0   = 1'b0;
    logic                    c1   = 1'b0;
    logic [7:0]              d    = 8'd0;
    logic [9:0]              q;
    logic signed [CNT_W-1:0] disp;

    int    errors = 0;
    int    checks = 0;
    int    mcnt   = 0;
    bit    chk_range = 1'b0;
    word_t mpipe [2];

    tmds_encoder #(.CNT_W(CNT_W)) dut (
        .PCLK  (pclk),
        .RESET (rst),
        .DE    (de),
        .C0    (c0),
        .C1    (c1),
        .D     (d),
        .Q     (q),
        .DISP  (disp)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // DVI 1.0 encoding of one word with integer disparity bookkeeping
    function automatic logic [9:0] model_step(input word_t w);
        int         n1, n1q, n0q;
        bit         xn;
        bit [8:0]   qm;
        logic [9:0] r;
        if (!w.de) begin
            mcnt = 0;
            case (w.c)
                2'b00: r = 10'h354;
                2'b01: r = 10'h0AB;
                2'b10: r = 10'h154;
                default: r = 10'h2AB;
            endcase
            return r;
        end
        n1    = $countones(w.d);
        xn    = (n1 > 4) || (n1 == 4 && w.d[0] == 1'b0);
        qm    = '0;
        qm[0] = w.d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ w.d[i]) : (qm[i-1] ^ w.d[i]);
        qm[8] = !xn;
        n1q   = $countones(qm[7:0]);
        n0q   = 8 - n1q;
        if (mcnt == 0 || n1q == n0q) begin
            r    = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((mcnt > 0 && n1q > n0q) || (mcnt < 0 && n0q > n1q)) begin
            r    = {1'b1, qm[8], ~qm[7:0]};
            mcnt = mcnt + (qm[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            r    = {1'b0, qm[8], qm[7:0]};
            mcnt = mcnt + (qm[8] ? 0 : -2) + (n1q - n0q);
        end
        return r;
    endfunction

    // Compare process: model advances on each edge, DUT outputs checked 1 time unit later
    initial begin
        logic [9:0] exp_q;
        mpipe[0] = '0;
        mpipe[1] = '0;
        forever begin
            @(posedge pclk or posedge rst);
            if (rst) begin
                mpipe[0] = '0;
                mpipe[1] = '0;
                mcnt     = 0;
                #1;
                chk("rst_q", int'(q), 0);
                chk("rst_disp", int'(disp), 0);
            end else begin
                exp_q    = model_step(mpipe[1]);
                mpipe[1] = mpipe[0];
                mpipe[0] = '{de: de, c: {c1, c0}, d: d};
                #1;
                chk("model_q", int'(q), int'(exp_q));
                chk("model_disp", int'(disp), mcnt);
                if (chk_range) chk("disp_range", int'(disp > 10 || disp < -10), 0);
            end
        end
    end

    task automatic drive(input bit de_v, input bit [1:0] c_v, input bit [7:0] d_v);
        de = de_v;
        c1 = c_v[1];
        c0 = c_v[0];
        d  = d_v;
        @(negedge pclk);
    endtask

    task automatic lit(input string name, input int exp_q, input int exp_disp);
        chk({name, "_q"}, int'(q), exp_q);
        chk({name, "_disp"}, int'(disp), exp_disp);
    endtask

    initial begin
        int burst;
        bit rde;

        // Reset held for three cycles, then idle control 00
        repeat (3) @(negedge pclk);
        lit("reset", 0, 0);
        rst = 1'b0;
        drive(0, 2'b00, 8'h00);
        lit("idle_first", 10'h354, 0);
        drive(0, 2'b00, 8'h00);
        drive(0, 2'b00, 8'h00);
        lit("idle", 10'h354, 0);

        // Control tokens, three edges after their input
        drive(0, 2'b01, 8'h00);
        drive(0, 2'b10, 8'h00);
        drive(0, 2'b11, 8'h00);
        lit("tok01", 10'h0AB, 0);
        drive(0, 2'b00, 8'h00);
        lit("tok10", 10'h154, 0);
        drive(0, 2'b00, 8'h00);
        lit("tok11", 10'h2AB, 0);

        // Zeros exercise all three balance branches
        drive(1, 2'b00, 8'h00);
        drive(1, 2'b00, 8'h00);
        drive(1, 2'b00, 8'h00);
        lit("zero0", 10'h100, -8);
        drive(1, 2'b00, 8'h00);
        lit("zero1", 10'h3FF, 2);
        drive(0, 2'b00, 8'h00);
        lit("zero2", 10'h100, -6);
        drive(0, 2'b00, 8'h00);
        lit("zero3", 10'h3FF, 4);
        drive(0, 2'b00, 8'h00);
        lit("zero_ctl", 10'h354, 0);

        // XNOR path, then one control word clears disparity
        drive(1, 2'b00, 8'hFF);
        drive(0, 2'b01, 8'h00);
        drive(0, 2'b00, 8'h00);
        lit("xnor_ff", 10'h200, -8);
        drive(0, 2'b00, 8'h00);
        lit("xnor_ctl", 10'h0AB, 0);

        // Asynchronous reset mid-stream drops the two in-flight words
        drive(1, 2'b00, 8'h3C);
        drive(1, 2'b00, 8'h5A);
        #2 rst = 1'b1;
        #1 lit("mid_rst", 0, 0);
        @(negedge pclk);
        rst = 1'b0;
        de  = 1'b0;
        drive(0, 2'b00, 8'h00);
        lit("post_rst0", 10'h354, 0);
        drive(0, 2'b00, 8'h00);
        lit("post_rst1", 10'h354, 0);

        // Random DE bursts; D is random during control too and must be ignored
        chk_range = 1'b1;
        burst = 0;
        rde   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (burst == 0) begin
                rde   = ~rde;
                burst = $urandom_range(1, 40);
            end
            burst--;
            drive(rde, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        repeat (3) drive(0, 2'b00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
